// File: rtl/kbd_led_sequencer.sv
// Keyboard LED update sequencer: sends ED + LED mask to a PS/2 keyboard,
// waits for FA acknowledges with resend/timeout handling, and forwards all
// other received bytes to the scancode converter.
module kbd_led_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [1:0]  MAX_RETRY      = 2'd3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] leds_in,
  input  logic [7:0] rx_code,
  input  logic       rx_strobe,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_busy,
  output logic [7:0] pass_code,
  output logic       pass_strobe,
  output logic       busy,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ACK1,
    S_MASK,
    S_ACK2
  } state_t;

  localparam logic [7:0]  CMD_SET_LEDS = 8'hED;
  localparam logic [7:0]  RSP_ACK      = 8'hFA;
  localparam logic [7:0]  RSP_RESEND   = 8'hFE;
  localparam logic [7:0]  RSP_BAT      = 8'hAA;
  localparam logic [15:0] TIMER_LAST   = TIMEOUT_CYCLES - 16'd1;

  state_t      state_q, state_d;
  logic [2:0]  shadow_q, shadow_d;
  logic        shadow_valid_q, shadow_valid_d;
  logic [2:0]  target_q, target_d;
  logic [1:0]  retry_q, retry_d;
  logic [15:0] timer_q, timer_d;
  logic        error_q, error_d;
  logic        bat_q, bat_d;
  logic        tx_req_q, tx_req_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  pass_code_q, pass_code_d;
  logic        pass_strobe_q, pass_strobe_d;

  logic in_ack, ack_rx, nak_rx, timeout, resend;

  // Decode replies and timeout for the acknowledge-wait states
  always_comb begin
    in_ack  = (state_q == S_ACK1) || (state_q == S_ACK2);
    ack_rx  = in_ack && rx_strobe && (rx_code == RSP_ACK);
    nak_rx  = in_ack && rx_strobe && (rx_code == RSP_RESEND);
    timeout = in_ack && (timer_q == TIMER_LAST);
    // A reply arriving on the timeout cycle wins over the timeout
    resend  = nak_rx || (timeout && !ack_rx);
  end

  // Next-state, transmit, shadow and forwarding logic
  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    target_d       = target_q;
    retry_d        = retry_q;
    timer_d        = timer_q;
    error_d        = error_q;
    bat_d          = bat_q;
    tx_req_d       = 1'b0;
    tx_data_d      = tx_data_q;
    pass_code_d    = pass_code_q;
    pass_strobe_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!shadow_valid_q || (leds_in != shadow_q)) begin
          target_d = leds_in;
          retry_d  = '0;
          bat_d    = 1'b0;
          state_d  = S_CMD;
        end
      end
      S_CMD: begin
        if (!tx_busy) begin
          tx_req_d  = 1'b1;
          tx_data_d = CMD_SET_LEDS;
          timer_d   = '0;
          state_d   = S_ACK1;
        end
      end
      S_MASK: begin
        if (!tx_busy) begin
          tx_req_d  = 1'b1;
          tx_data_d = {5'b0, target_q};
          timer_d   = '0;
          state_d   = S_ACK2;
        end
      end
      S_ACK1, S_ACK2: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 16'd1;
        if (ack_rx) begin
          if (state_q == S_ACK1) begin
            retry_d = '0;
            state_d = S_MASK;
          end else begin
            // A BAT seen during the sequence keeps the shadow invalid so
            // the mask is re-sent once this sequence has finished
            shadow_d       = target_q;
            shadow_valid_d = ~bat_q;
            error_d        = 1'b0;
            state_d        = S_IDLE;
          end
        end else if (resend) begin
          if (retry_q == MAX_RETRY) begin
            error_d        = 1'b1;
            shadow_d       = target_q;
            shadow_valid_d = ~bat_q;
            state_d        = S_IDLE;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = (state_q == S_ACK1) ? S_CMD : S_MASK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Forwarding and BAT handling last so a same-cycle BAT overrides
    if (rx_strobe && !(in_ack && ((rx_code == RSP_ACK) || (rx_code == RSP_RESEND)))) begin
      pass_code_d   = rx_code;
      pass_strobe_d = 1'b1;
    end
    if (rx_strobe && (rx_code == RSP_BAT)) begin
      shadow_valid_d = 1'b0;
      bat_d          = 1'b1;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      target_q       <= '0;
      retry_q        <= '0;
      timer_q        <= '0;
      error_q        <= 1'b0;
      bat_q          <= 1'b0;
      tx_req_q       <= 1'b0;
      tx_data_q      <= '0;
      pass_code_q    <= '0;
      pass_strobe_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      target_q       <= target_d;
      retry_q        <= retry_d;
      timer_q        <= timer_d;
      error_q        <= error_d;
      bat_q          <= bat_d;
      tx_req_q       <= tx_req_d;
      tx_data_q      <= tx_data_d;
      pass_code_q    <= pass_code_d;
      pass_strobe_q  <= pass_strobe_d;
    end
  end

  assign tx_req      = tx_req_q;
  assign tx_data     = tx_data_q;
  assign pass_code   = pass_code_q;
  assign pass_strobe = pass_strobe_q;
  assign busy        = (state_q != S_IDLE);
  assign error       = error_q;

endmodule

// File: tb/tb_kbd_led_sequencer.sv
// Bench for kbd_led_sequencer: the bench plays the keyboard, predicts the
// transmitted bytes and forwarded codes into queues, and a monitor checks them.
module tb_kbd_led_sequencer;

  localparam logic [15:0] T  = 16'd24;
  localparam logic [1:0]  MR = 2'd3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] leds_in;
  logic [7:0] rx_code;
  logic       rx_strobe;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy;
  logic [7:0] pass_code;
  logic       pass_strobe;
  logic       busy;
  logic       error;

  always #5 clock = ~clock;

  kbd_led_sequencer #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .clock(clock), .reset_n(reset_n), .leds_in(leds_in),
    .rx_code(rx_code), .rx_strobe(rx_strobe),
    .tx_data(tx_data), .tx_req(tx_req), .tx_busy(tx_busy),
    .pass_code(pass_code), .pass_strobe(pass_strobe),
    .busy(busy), .error(error)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] tx_q[$];
  logic [7:0] pass_q[$];
  bit mon_en = 0;

  // Keyboard-level model: last mask acknowledged, validity, BAT seen, error
  logic [2:0] m_shadow;
  bit m_valid, m_bat, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [7:0] act);
    total++;
    bad++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // Monitor: samples just after each rising edge
  always begin
    @(posedge clock);
    #2;
    if (mon_en) begin
      if (tx_req) begin
        check("tx_req_while_busy", tx_busy, 0);
        if (tx_q.size() == 0) unexpected("tx_unexpected", tx_data);
        else check("tx_data", tx_data, tx_q.pop_front());
      end
      if (pass_strobe) begin
        if (pass_q.size() == 0) unexpected("pass_unexpected", pass_code);
        else check("pass_code", pass_code, pass_q.pop_front());
      end
    end
  end

  task automatic send_rx(input logic [7:0] code, input bit fwd);
    rx_code   = code;
    rx_strobe = 1'b1;
    if (fwd) pass_q.push_back(code);
    @(negedge clock);
    rx_strobe = 1'b0;
  endtask

  task automatic send_extra();
    logic [7:0] c;
    c = 8'($urandom);
    while (c == 8'hFA || c == 8'hFE) c = 8'($urandom);
    if ($urandom % 3 == 0) c = 8'hAA;
    if (c == 8'hAA) m_bat = 1;
    send_rx(c, 1);
  endtask

  task automatic wait_tx(input int hold, output bit ok);
    ok = 0;
    for (int i = 0; i < hold + int'(T) + 40; i++) begin
      if (i >= hold) tx_busy = 1'b0;
      @(negedge clock);
      if (tx_req) begin
        ok = 1;
        break;
      end
    end
  endtask

  // mode 0: random replies, 1: always acknowledge, 2: never reply
  task automatic do_sequence(input logic [2:0] target, input int mode);
    logic [7:0] bytes [2];
    bit aborted, ok, flaky, inject;
    int tries, hold, d, r;
    bytes[0] = 8'hED;
    bytes[1] = {5'b0, target};
    aborted = 0;
    hold = 0;
    m_bat = 0;
    flaky = (mode == 0) && ($urandom % 4 == 0);
    for (int b = 0; b < 2 && !aborted; b++) begin
      tries = 0;
      forever begin
        tx_q.push_back(bytes[b]);
        wait_tx(hold, ok);
        hold = 0;
        check("tx_within_bound", ok, 1);
        if (!ok) begin
          tx_busy = 1'b0;
          return;
        end
        if (mode == 0 && $urandom % 6 == 0) leds_in = 3'($urandom);
        if (mode == 1) r = 0;
        else if (mode == 2) r = 2;
        else begin
          r = $urandom % 8;
          if (flaky) r = (r == 0) ? 0 : ((r < 4) ? 1 : 2);
          else       r = (r < 5) ? 0 : ((r == 5) ? 1 : 2);
        end
        inject = (mode == 0) && ($urandom % 3 == 0);
        if (r == 2) begin
          if (inject) send_extra();
        end else begin
          d = int'($urandom_range(0, int'(T) - 1));
          if (d < 2) inject = 0;
          for (int c = 0; c < d; c++) begin
            if (c == 0 && inject) send_extra();
            else @(negedge clock);
          end
          hold = (mode == 0) ? int'($urandom_range(0, 12)) : 0;
          if (hold > 0) tx_busy = 1'b1;
          send_rx((r == 0) ? 8'hFA : 8'hFE, 0);
        end
        if (r == 0) break;
        tries++;
        if (tries > int'(MR)) begin
          aborted = 1;
          break;
        end
      end
    end
    m_err    = aborted;
    m_shadow = target;
    m_valid  = !m_bat;
    for (int i = 0; i < int'(T) + 20; i++) begin
      if (!busy) break;
      @(negedge clock);
    end
    tx_busy = 1'b0;
    check("idle_after_seq", busy, 0);
    check("error_flag", error, m_err);
  endtask

  task automatic idle_action();
    logic [7:0] c;
    int sel;
    sel = $urandom % 4;
    if (sel == 0) begin
      leds_in = 3'($urandom);
    end else if (sel == 1) begin
      sel = $urandom % 8;
      c = (sel < 2) ? 8'hAA : (sel == 2) ? 8'hFA : (sel == 3) ? 8'hFE : 8'($urandom);
      if (c == 8'hAA) m_valid = 0;
      send_rx(c, 1);
      @(negedge clock);
    end else begin
      repeat (int'($urandom_range(1, 6))) @(negedge clock);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    bit ok;
    reset_n   = 1'b0;
    leds_in   = 3'b100;
    rx_code   = '0;
    rx_strobe = 1'b0;
    tx_busy   = 1'b0;
    m_shadow  = '0;
    m_valid   = 0;
    m_bat     = 0;
    m_err     = 0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_pass_strobe", pass_strobe, 0);
    check("rst_pass_code", pass_code, 0);
    mon_en  = 1;
    reset_n = 1'b1;

    do_sequence(3'b100, 1);

    leds_in = 3'b011;
    do_sequence(3'b011, 2);
    repeat (40) @(negedge clock);
    check("no_tx_after_abort", busy, 0);

    for (int it = 0; it < 60; it++) begin
      if (!m_valid || leds_in != m_shadow) do_sequence(leds_in, 0);
      else idle_action();
    end
    for (int k = 0; k < 10 && (!m_valid || leds_in != m_shadow); k++)
      do_sequence(leds_in, 0);

    leds_in = ~m_shadow;
    tx_q.push_back(8'hED);
    wait_tx(0, ok);
    check("pre_reset_tx", ok, 1);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    repeat (4) @(negedge clock);
    check("midrst_busy", busy, 0);
    check("midrst_error", error, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_tx_req", tx_req, 0);
    m_valid = 0;
    m_err   = 0;
    m_bat   = 0;
    reset_n = 1'b1;
    do_sequence(leds_in, 1);

    repeat (8) @(negedge clock);
    check("tx_queue_drained", tx_q.size(), 0);
    check("pass_queue_drained", pass_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
